control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - two-byte instruction control sequencer
// Fetches opcode and immediate, decodes, runs memory phases and drives datapath strobes.
module control_sequencer #(
    parameter int FWIDTH  = 4,
    parameter int ALUCTLW = 4
) (
    input  logic               clk,
    input  logic               res,
    input  logic [7:0]         mem_rdata,
    input  logic               mem_ack,
    input  logic [FWIDTH-1:0]  flags,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic [7:0]         immediate,
    output logic [1:0]         ac_source,
    output logic               write_ac,
    output logic               mar_source,
    output logic               write_mar,
    output logic [1:0]         mdr_source,
    output logic               write_mdr,
    output logic               write_flags,
    output logic [1:0]         pc_source,
    output logic               write_pc,
    output logic [2:0]         ALU_op_select,
    output logic [ALUCTLW-1:0] ALUctl,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_IMM,
        DECODE,
        MEM_RD,
        MEM_WR,
        EXEC,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ALUI = 4'h4;
    localparam logic [3:0] OP_ALUM = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] imm_q, imm_d;
    logic [3:0] op_class;
    logic       zero_flag;

    // Only the zero flag steers sequencing; the remaining flag bits are datapath-only.
    logic unused_flags;
    assign unused_flags = ^flags;

    assign op_class  = opcode_q[7:4];
    assign zero_flag = flags[0];
    assign immediate = imm_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= FETCH_OP;
            opcode_q <= 8'h00;
            imm_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        imm_d         = imm_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ac_source     = 2'b00;
        write_ac      = 1'b0;
        mar_source    = 1'b0;
        write_mar     = 1'b0;
        mdr_source    = 2'b00;
        write_mdr     = 1'b0;
        write_flags   = 1'b0;
        pc_source     = 2'b00;
        write_pc      = 1'b0;
        ALU_op_select = 3'b000;
        ALUctl        = '0;
        halted        = 1'b0;
        illegal       = 1'b0;

        // Everything stays quiet while reset is held, even though state already reads FETCH_OP.
        if (!res) begin
            unique case (state_q)
                FETCH_OP: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        write_pc = 1'b1;
                        opcode_d = mem_rdata;
                        state_d  = FETCH_IMM;
                    end
                end
                FETCH_IMM: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        write_pc = 1'b1;
                        imm_d    = mem_rdata;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    state_d = FETCH_OP;
                    case (op_class)
                        OP_NOP: ;
                        OP_LDI: begin
                            ac_source = 2'b11;
                            write_ac  = 1'b1;
                        end
                        OP_ALUI: begin
                            ALU_op_select = 3'b110;
                            ALUctl        = ALUCTLW'(opcode_q);
                            ac_source     = 2'b10;
                            write_ac      = 1'b1;
                            write_flags   = 1'b1;
                        end
                        OP_JMP: begin
                            pc_source = 2'b01;
                            write_pc  = 1'b1;
                        end
                        OP_JZ: begin
                            if (zero_flag) begin
                                pc_source = 2'b01;
                                write_pc  = 1'b1;
                            end
                        end
                        OP_LD, OP_ALUM: begin
                            mar_source = 1'b1;
                            write_mar  = 1'b1;
                            state_d    = MEM_RD;
                        end
                        OP_ST: begin
                            mar_source = 1'b1;
                            write_mar  = 1'b1;
                            mdr_source = 2'b11;
                            write_mdr  = 1'b1;
                            state_d    = MEM_WR;
                        end
                        OP_HLT: state_d = HALT;
                        default: illegal = 1'b1;
                    endcase
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ack) begin
                        mdr_source = 2'b01;
                        write_mdr  = 1'b1;
                        state_d    = EXEC;
                    end
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ack) begin
                        state_d = FETCH_OP;
                    end
                end
                EXEC: begin
                    state_d = FETCH_OP;
                    if (op_class == OP_ALUM) begin
                        ALU_op_select = 3'b111;
                        ALUctl        = ALUCTLW'(opcode_q);
                        ac_source     = 2'b10;
                        write_ac      = 1'b1;
                        write_flags   = 1'b1;
                    end else begin
                        ac_source = 2'b01;
                        write_ac  = 1'b1;
                    end
                end
                HALT: halted = 1'b1;
                default: state_d = FETCH_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized instruction-trace bench for control_sequencer
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [3:0] flags;
    logic       mem_req, mem_we, addr_sel;
    logic [7:0] immediate;
    logic [1:0] ac_source, mdr_source, pc_source;
    logic       write_ac, mar_source, write_mar, write_mdr, write_flags, write_pc;
    logic [2:0] ALU_op_select;
    logic [3:0] ALUctl;
    logic       halted, illegal;

    control_sequencer #(.FWIDTH(4), .ALUCTLW(4)) dut (
        .clk(clk), .res(res), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .flags(flags),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .immediate(immediate),
        .ac_source(ac_source), .write_ac(write_ac), .mar_source(mar_source),
        .write_mar(write_mar), .mdr_source(mdr_source), .write_mdr(write_mdr),
        .write_flags(write_flags), .pc_source(pc_source), .write_pc(write_pc),
        .ALU_op_select(ALU_op_select), .ALUctl(ALUctl), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, we, asel;
        logic [1:0] acs;
        logic       wac, mars, wmar;
        logic [1:0] mdrs;
        logic       wmdr, wflg;
        logic [1:0] pcs;
        logic       wpc;
        logic [2:0] alu;
        logic [3:0] aluctl;
        logic       halted, illegal;
        logic [7:0] imm;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic       ack;
        logic [7:0] rdata;
        logic       flag0;
        ctl_t       exp;
    } step_t;

    step_t      plan[$];
    logic [7:0] cur_imm = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;
    ctl_t       exp_q;
    bit         exp_valid = 1'b0;
    int         step_no = 0;

    function automatic ctl_t act();
        return {mem_req, mem_we, addr_sel, ac_source, write_ac, mar_source, write_mar,
                mdr_source, write_mdr, write_flags, pc_source, write_pc, ALU_op_select,
                ALUctl, halted, illegal, immediate};
    endfunction

    function automatic ctl_t blank();
        ctl_t c = '0;
        c.imm = cur_imm;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            n_cmp++;
            if (act() !== exp_q) begin
                n_bad++;
                $display("FAIL step%0d: got %h required %h", step_no, act(), exp_q);
            end
        end
    end

    task automatic push(input ctl_t c, input logic ack, input logic [7:0] rd,
                        input logic f, input logic rst);
        step_t s;
        s.rst = rst; s.ack = ack; s.rdata = rd; s.flag0 = f; s.exp = c;
        plan.push_back(s);
    endtask

    task automatic add_reset(input int n);
        cur_imm = 8'h00;
        for (int i = 0; i < n; i++) push(blank(), 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    endtask

    // One memory transfer: `waits` idle-request cycles, then the acknowledged cycle.
    task automatic add_access(input int waits, input ctl_t base, input ctl_t on_ack,
                              input logic [7:0] data);
        for (int i = 0; i < waits; i++) push(base, 1'b0, 8'($urandom), 1'($urandom), 1'b0);
        push(on_ack, 1'b1, data, 1'($urandom), 1'b0);
    endtask

    task automatic add_instr(input logic [7:0] op, input logic [7:0] imm,
                             input int w1, input int w2, input int w3);
        ctl_t b, a, d, e;
        logic f;
        b = blank(); b.req = 1'b1; a = b; a.wpc = 1'b1;
        add_access(w1, b, a, op);
        add_access(w2, b, a, imm);
        cur_imm = imm;
        d = blank();
        f = 1'($urandom);
        case (op[7:4])
            4'h0, 4'hF: ;
            4'h1: begin d.acs = 2'd3; d.wac = 1'b1; end
            4'h2, 4'h5: begin d.mars = 1'b1; d.wmar = 1'b1; end
            4'h3: begin d.mars = 1'b1; d.wmar = 1'b1; d.mdrs = 2'd3; d.wmdr = 1'b1; end
            4'h4: begin
                d.alu = 3'd6; d.acs = 2'd2; d.wac = 1'b1; d.wflg = 1'b1; d.aluctl = op[3:0];
            end
            4'h6: begin d.pcs = 2'd1; d.wpc = 1'b1; end
            4'h7: if (f) begin d.pcs = 2'd1; d.wpc = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        push(d, 1'($urandom), 8'($urandom), f, 1'b0);
        if (op[7:4] == 4'h2 || op[7:4] == 4'h5) begin
            b = blank(); b.req = 1'b1; b.asel = 1'b1;
            a = b; a.mdrs = 2'd1; a.wmdr = 1'b1;
            add_access(w3, b, a, 8'($urandom));
            e = blank(); e.wac = 1'b1;
            if (op[7:4] == 4'h2) e.acs = 2'd1;
            else begin e.alu = 3'd7; e.acs = 2'd2; e.wflg = 1'b1; e.aluctl = op[3:0]; end
            push(e, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end else if (op[7:4] == 4'h3) begin
            b = blank(); b.req = 1'b1; b.we = 1'b1; b.asel = 1'b1;
            add_access(w3, b, b, 8'($urandom));
        end else if (op[7:4] == 4'hF) begin
            e = blank(); e.halted = 1'b1;
            for (int i = 0; i < 4; i++) push(e, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            add_reset(1);
        end
    endtask

    task automatic run_plan();
        foreach (plan[i]) begin
            @(posedge clk); #1;
            res       = plan[i].rst;
            mem_ack   = plan[i].ack;
            mem_rdata = plan[i].rdata;
            flags     = {3'($urandom), plan[i].flag0};
            exp_q     = plan[i].exp;
            step_no   = i;
            exp_valid = 1'b1;
        end
        @(posedge clk); #1;
        exp_valid = 1'b0;
        plan.delete();
    endtask

    task automatic hold_reset();
        @(posedge clk); #1; res = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int  cyc, wcnt, k;
        bit  done;
        logic [7:0] op;
        res = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; flags = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", act(), 32'h0);

        // LDI with ack tied high: accumulator load lands in cycle 3, next fetch in cycle 4.
        @(posedge clk); #1; res = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h10;
        @(negedge clk); chk("ldi_c1_fetch", {mem_req, addr_sel}, 32'h2);
        @(posedge clk); #1; mem_rdata = 8'h5A;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldi_c3_wac", {write_ac, ac_source}, 32'h7);
        chk("ldi_c3_imm", immediate, 32'h5A);
        @(posedge clk); #1;
        @(negedge clk); chk("ldi_c4_req", {mem_req, addr_sel}, 32'h2);
        hold_reset();

        // LD with every access acknowledged two cycles late completes in cycle 11.
        res = 1'b0; cyc = 0; wcnt = 0; k = 0; done = 1'b0;
        while (cyc < 30 && !done) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            cyc++;
            mem_rdata = (k == 0) ? 8'h20 : 8'h80;
            mem_ack   = (wcnt == 2);
            @(negedge clk);
            if (mem_req) begin
                if (mem_ack) begin wcnt = 0; if (!addr_sel) k++; end
                else wcnt++;
            end
            if (write_ac) begin
                done = 1'b1;
                chk("ld_total_cycles", cyc, 32'd11);
                chk("ld_exec_acsrc", ac_source, 32'd1);
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL ld_timeout: got no write_ac required write_ac by cycle 11");
        end
        hold_reset();

        // Illegal opcode pulse, directed.
        res = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h85;
        @(posedge clk); #1; mem_rdata = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("illegal_pulse", {illegal, write_ac, write_mar, write_mdr, write_pc, write_flags}, 32'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("illegal_next_fetch", {illegal, mem_req, addr_sel}, 32'h2);
        hold_reset();
        res = 1'b0;

        // Randomized instruction stream checked against the trace model.
        add_reset(2);
        add_instr(8'h10, 8'h5A, 0, 0, 0);
        add_instr(8'h70, 8'h20, 1, 0, 0);
        add_instr(8'h30, 8'h40, 0, 2, 1);
        for (int i = 0; i < 60; i++) begin
            if (i == 7) op = 8'h85;
            else if (i == 15) op = 8'hF0;
            else op = 8'($urandom);
            add_instr(op, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2));
            if (i == 25) begin
                add_instr(8'h2C, 8'h99, 0, 0, 3);
                for (int j = 0; j < 4; j++) void'(plan.pop_back());
                add_reset(2);
            end
        end
        add_instr(8'hFF, 8'hFF, 0, 0, 0);
        run_plan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of run required end within 200000");
        $fatal(1);
    end

endmodule
